// File: rtl/mc_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// instruction classes, ALU operations and datapath mux selects.
package mc_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BR,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_BAD
    } inst_class_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic inst_class_e classify(input logic [6:0] op);
        case (op)
            OP_R:     return CLS_R;
            OP_I:     return CLS_I;
            OP_LOAD:  return CLS_LOAD;
            OP_STORE: return CLS_STORE;
            OP_BR:    return CLS_BR;
            OP_JAL:   return CLS_JAL;
            OP_JALR:  return CLS_JALR;
            OP_LUI:   return CLS_LUI;
            OP_AUIPC: return CLS_AUIPC;
            default:  return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU operation decode from the registered instruction class,
// funct3 and funct7[5].
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [3:0] cls,
    input  logic [2:0] f3,
    input  logic       f7b5,
    output logic [3:0] alu_op
);

    alu_op_e op;

    // For OP-IMM, funct7[5] only matters for shifts; ADDI has no SUB form.
    always_comb begin
        op = ALU_ADD;
        case (cls)
            CLS_R, CLS_I: begin
                case (f3)
                    3'd0:    op = (cls == CLS_R && f7b5) ? ALU_SUB : ALU_ADD;
                    3'd1:    op = ALU_SLL;
                    3'd2:    op = ALU_SLT;
                    3'd3:    op = ALU_SLTU;
                    3'd4:    op = ALU_XOR;
                    3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
                    3'd6:    op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            CLS_BR:  op = ALU_SUB;
            CLS_LUI: op = ALU_PASS_B;
            default: op = ALU_ADD;
        endcase
    end

    assign alu_op = op;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing, memory timeout detection and retired-instruction counting.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int MEM_TMO = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_en,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             a_sel,
    output logic             b_sel,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic             bus_fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;

    state_e            state;
    inst_class_e       class_q;
    inst_class_e       class_d;
    logic [2:0]        f3_q;
    logic              f7b5_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        alu_dec;
    logic              timeout;
    logic              retire;
    logic              unused_f7;

    // Only funct7[5] distinguishes SUB/SRA in RV32I.
    assign unused_f7 = ^{funct7[6], funct7[4:0]};
    assign class_d   = classify(opcode);

    // Fires on the MEM_TMO-th consecutive not-ready cycle; ready wins that cycle.
    assign timeout = (MEM_TMO != 0) && (int'(wait_cnt) == MEM_TMO - 1);

    assign retire = (state == S_EXEC && class_q == CLS_BR) ||
                    (state == S_MEM && class_q == CLS_STORE && dmem_ready) ||
                    (state == S_WB);

    mc_alu_dec u_alu_dec (
        .cls    (class_q),
        .f3     (f3_q),
        .f7b5   (f7b5_q),
        .alu_op (alu_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            class_q   <= CLS_R;
            f3_q      <= 3'd0;
            f7b5_q    <= 1'b0;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_fault <= 1'b0;
            retired   <= '0;
        end else begin
            if (retire) retired <= retired + CNT_W'(1);
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else if (timeout) begin
                        wait_cnt  <= '0;
                        bus_fault <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    class_q <= class_d;
                    f3_q    <= funct3;
                    f7b5_q  <= funct7[5];
                    if (class_d == CLS_BAD) begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (class_q == CLS_BR) state <= S_FETCH;
                    else if (class_q == CLS_LOAD || class_q == CLS_STORE) state <= S_MEM;
                    else state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        state    <= (class_q == CLS_STORE) ? S_FETCH : S_WB;
                    end else if (timeout) begin
                        wait_cnt  <= '0;
                        bus_fault <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_HALT;
            endcase
        end
    end

    // ALU controls stay valid from EXEC through WB so addresses and JALR targets hold.
    always_comb begin
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_PLUS4;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        alu_op   = ALU_ADD;
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            alu_op = alu_dec;
            a_sel  = (class_q == CLS_AUIPC);
            b_sel  = !(class_q == CLS_R || class_q == CLS_BR);
        end
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_ready;
            end
            S_EXEC: begin
                if (class_q == CLS_BR) begin
                    pc_en  = 1'b1;
                    pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == CLS_STORE);
                pc_en    = (class_q == CLS_STORE) && dmem_ready;
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_en = 1'b1;
                if (class_q == CLS_LOAD) wb_sel = WB_MEM;
                else if (class_q == CLS_JAL || class_q == CLS_JALR) wb_sel = WB_PC4;
                if (class_q == CLS_JAL) pc_sel = PC_IMM;
                else if (class_q == CLS_JALR) pc_sel = PC_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction
// phase model built from the instruction-class rules.
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int CNT_W   = 4;
    localparam int MEM_TMO = 4;

    typedef struct packed {
        logic       imem_req;
        logic       ir_en;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       a_sel;
        logic       b_sel;
        logic [3:0] alu_op;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic br_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we, a_sel, b_sel, illegal, bus_fault;
    logic [1:0] pc_sel, wb_sel;
    logic [3:0] alu_op;
    logic [CNT_W-1:0] retired;

    int tests = 0;
    int failed = 0;
    logic [CNT_W-1:0] model_ret = '0;
    outs_t obs;

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_en, dmem_req, dmem_we, pc_en, pc_sel, rf_we, wb_sel, a_sel, b_sel, alu_op};

    mc_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_en(ir_en),
        .pc_en(pc_en), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .a_sel(a_sel),
        .b_sel(b_sel), .alu_op(alu_op), .illegal(illegal), .bus_fault(bus_fault),
        .retired(retired)
    );

    function automatic logic [3:0] ref_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Datapath controls expected from EXEC onward for a given instruction.
    function automatic outs_t ref_datapath(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        outs_t w;
        w = '0;
        w.a_sel = (op == OP_AUIPC);
        w.b_sel = !(op == OP_R || op == OP_BR);
        if (op == OP_R) w.alu_op = ref_arith(f3, f7[5]);
        else if (op == OP_I) w.alu_op = ref_arith(f3, f7[5] && f3 == 3'd5);
        else if (op == OP_BR) w.alu_op = ALU_SUB;
        else if (op == OP_LUI) w.alu_op = ALU_PASS_B;
        else w.alu_op = ALU_ADD;
        return w;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
        #1;
        tests++;
        if (obs !== '0 || illegal !== 1'b0 || bus_fault !== 1'b0 || retired !== '0) begin
            failed++;
            $display("[TB] FAIL reset_state: outs=%h ill=%b bf=%b ret=%0d, want all zero", obs, illegal, bus_fault, retired);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ret = '0;
        #1;
        tests++;
        if (obs !== '0) begin
            failed++;
            $display("[TB] FAIL idle_outputs: got %h want 0", obs);
        end
        @(posedge clk);
    endtask

    // Runs one instruction from FETCH to retirement, checking every cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fd, input int md, input logic tk);
        outs_t base, want;
        logic is_ld, is_st;
        base  = ref_datapath(op, f3, f7);
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        for (int k = 0; k <= fd; k++) begin
            @(negedge clk);
            imem_ready = (k == fd); opcode = op; funct3 = f3; funct7 = f7; dmem_ready = 1'b0;
            #1;
            want = '0; want.imem_req = 1'b1; want.ir_en = (k == fd);
            tests++;
            if (obs !== want) begin
                failed++;
                $display("[TB] FAIL fetch op=%b k=%0d: got %h want %h", op, k, obs, want);
            end
            @(posedge clk);
        end
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        tests++;
        if (obs !== '0) begin
            failed++;
            $display("[TB] FAIL decode op=%b: got %h want 0", op, obs);
        end
        @(posedge clk);
        @(negedge clk);
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom); br_taken = tk;
        #1;
        want = base;
        if (op == OP_BR) begin
            want.pc_en = 1'b1;
            want.pc_sel = tk ? PC_IMM : PC_PLUS4;
        end
        tests++;
        if (obs !== want) begin
            failed++;
            $display("[TB] FAIL exec op=%b f3=%0d: got %h want %h", op, f3, obs, want);
        end
        @(posedge clk);
        if (is_ld || is_st) begin
            for (int k = 0; k <= md; k++) begin
                @(negedge clk);
                dmem_ready = (k == md);
                #1;
                want = base; want.dmem_req = 1'b1; want.dmem_we = is_st;
                want.pc_en = is_st && (k == md);
                tests++;
                if (obs !== want) begin
                    failed++;
                    $display("[TB] FAIL mem op=%b k=%0d: got %h want %h", op, k, obs, want);
                end
                @(posedge clk);
            end
        end
        if (op != OP_BR && !is_st) begin
            @(negedge clk);
            dmem_ready = 1'b0;
            #1;
            want = base; want.rf_we = 1'b1; want.pc_en = 1'b1;
            want.wb_sel = is_ld ? WB_MEM : (op == OP_JAL || op == OP_JALR) ? WB_PC4 : WB_ALU;
            want.pc_sel = (op == OP_JAL) ? PC_IMM : (op == OP_JALR) ? PC_ALU : PC_PLUS4;
            tests++;
            if (obs !== want) begin
                failed++;
                $display("[TB] FAIL wb op=%b: got %h want %h", op, obs, want);
            end
            @(posedge clk);
        end
        model_ret = model_ret + 1'b1;
        #1;
        tests++;
        if (retired !== model_ret || illegal !== 1'b0 || bus_fault !== 1'b0) begin
            failed++;
            $display("[TB] FAIL retire op=%b: ret=%0d ill=%b bf=%b want ret=%0d ill=0 bf=0", op, retired, illegal, bus_fault, model_ret);
        end
    endtask

    task automatic test_basic();
        run_instr(OP_R, 3'd0, 7'h00, 0, 0, 1'b0);
        run_instr(OP_LOAD, 3'd2, 7'h00, 0, 3, 1'b0);
        run_instr(OP_STORE, 3'd2, 7'h00, 1, 2, 1'b0);
        run_instr(OP_BR, 3'd0, 7'h00, 0, 0, 1'b1);
        run_instr(OP_BR, 3'd1, 7'h00, 0, 0, 1'b0);
    endtask

    task automatic test_alu_paths();
        logic [6:0] ops [9] = '{OP_JALR, OP_I, OP_I, OP_I, OP_R, OP_LUI, OP_AUIPC, OP_JAL, OP_R};
        logic [2:0] f3s [9] = '{3'd0, 3'd5, 3'd5, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd7};
        logic [6:0] f7s [9] = '{7'h00, 7'h20, 7'h00, 7'h20, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00};
        for (int i = 0; i < 9; i++) run_instr(ops[i], f3s[i], f7s[i], 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int i = 0; i < 30; i++) begin
            run_instr(ops[$urandom_range(8)], 3'($urandom), 7'($urandom),
                      $urandom_range(MEM_TMO - 1), $urandom_range(MEM_TMO - 1), 1'($urandom));
        end
    endtask

    task automatic test_illegal();
        run_instr(OP_R, 3'd4, 7'h00, 0, 0, 1'b0);
        @(negedge clk);
        imem_ready = 1'b1; opcode = 7'b1111111;
        @(posedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (illegal !== 1'b1 || obs !== '0) begin
            failed++;
            $display("[TB] FAIL illegal_set: ill=%b outs=%h want ill=1 outs=0", illegal, obs);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            imem_ready = 1'b1;
            #1;
            tests++;
            if (imem_req !== 1'b0 || illegal !== 1'b1 || retired !== model_ret) begin
                failed++;
                $display("[TB] FAIL illegal_halt: req=%b ill=%b ret=%0d want req=0 ill=1 ret=%0d", imem_req, illegal, retired, model_ret);
            end
        end
        test_reset();
    endtask

    task automatic test_timeout();
        outs_t want;
        test_reset();
        for (int k = 0; k < MEM_TMO; k++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            #1;
            want = '0; want.imem_req = 1'b1;
            tests++;
            if (obs !== want || bus_fault !== 1'b0) begin
                failed++;
                $display("[TB] FAIL fetch_wait k=%0d: outs=%h bf=%b want %h bf=0", k, obs, bus_fault, want);
            end
            @(posedge clk);
        end
        #1;
        tests++;
        if (bus_fault !== 1'b1 || obs !== '0) begin
            failed++;
            $display("[TB] FAIL fetch_timeout: bf=%b outs=%h want bf=1 outs=0", bus_fault, obs);
        end
        repeat (3) @(negedge clk);
        imem_ready = 1'b1;
        #1;
        tests++;
        if (bus_fault !== 1'b1 || obs !== '0) begin
            failed++;
            $display("[TB] FAIL fault_hold: bf=%b outs=%h want bf=1 outs=0", bus_fault, obs);
        end
        test_reset();
        run_instr(OP_R, 3'd6, 7'h00, MEM_TMO - 1, 0, 1'b0);
        run_instr(OP_LOAD, 3'd0, 7'h00, 0, MEM_TMO - 1, 1'b0);
        test_reset();
        run_instr(OP_I, 3'd0, 7'h00, 0, 0, 1'b0);
        @(negedge clk); imem_ready = 1'b1; opcode = OP_LOAD;
        @(posedge clk);
        @(negedge clk); imem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < MEM_TMO; k++) begin
            @(negedge clk);
            dmem_ready = 1'b0;
            #1;
            tests++;
            if (dmem_req !== 1'b1 || bus_fault !== 1'b0) begin
                failed++;
                $display("[TB] FAIL mem_wait k=%0d: req=%b bf=%b want req=1 bf=0", k, dmem_req, bus_fault);
            end
            @(posedge clk);
        end
        #1;
        tests++;
        if (bus_fault !== 1'b1 || obs !== '0 || retired !== model_ret) begin
            failed++;
            $display("[TB] FAIL mem_timeout: bf=%b outs=%h ret=%0d want bf=1 outs=0 ret=%0d", bus_fault, obs, retired, model_ret);
        end
        test_reset();
    endtask

    task automatic test_reset_mid_access();
        test_reset();
        @(negedge clk);
        imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0) begin
            failed++;
            $display("[TB] FAIL async_imem_drop: got %b want 0", imem_req);
        end
        test_reset();
        @(negedge clk); imem_ready = 1'b1; opcode = OP_LOAD;
        @(posedge clk);
        @(negedge clk); imem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (dmem_req !== 1'b0 || rf_we !== 1'b0 || retired !== '0) begin
            failed++;
            $display("[TB] FAIL async_dmem_drop: req=%b we=%b ret=%0d want 0 0 0", dmem_req, rf_we, retired);
        end
        test_reset();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_alu_paths();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
